// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the N-deep MAC systolic chain: clear, load N weights, stream K activations,
// drain with zeros, then pulse done. One broadcast control word drives every MAC in the chain.
package mac_pkg;
  typedef enum logic [1:0] {
    MAC_CTRL_IDLE        = 2'd0,
    MAC_CTRL_CLR         = 2'd1,
    MAC_CTRL_LOAD_WEIGHT = 2'd2,
    MAC_CTRL_RUN         = 2'd3
  } mac_ctrl_t;
endpackage

module systolic_seq_ctrl
  import mac_pkg::*;
#(
  parameter int ARRAY_DIM = 4,
  parameter int K_MAX     = 256,
  parameter int PIPE_LAT  = 2*ARRAY_DIM-1,
  parameter int K_W       = $clog2(K_MAX+1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [K_W-1:0] cfg_k_i,
  output logic           busy_o,
  output logic           done_o,
  input  logic           w_valid_i,
  output logic           w_ready_o,
  input  logic           a_valid_i,
  output logic           a_ready_o,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output mac_ctrl_t      arr_ctrl_o,
  output logic [1:0]     arr_sel_o
);

  localparam int RC_W = $clog2(K_MAX+PIPE_LAT+1);
  localparam int W_W  = $clog2(ARRAY_DIM+1);
  localparam logic [RC_W-1:0] PIPE_LAT_C = RC_W'(PIPE_LAT);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LOAD, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t          state_q;
  logic [K_W-1:0]  k_q;
  logic [W_W-1:0]  wCnt_q;
  logic [RC_W-1:0] runCnt_q;
  logic            busy_q;
  logic            done_q;

  logic [K_W-1:0]  kClamped;
  logic [RC_W-1:0] kExt;
  logic [RC_W-1:0] lastStep;
  logic            res;
  logic            srcOk;
  logic            step;

  assign kClamped = (cfg_k_i > K_W'(K_MAX)) ? K_W'(K_MAX) : cfg_k_i;
  assign kExt     = RC_W'(k_q);
  assign lastStep = kExt + PIPE_LAT_C - RC_W'(1);

  // A result sits at the array output once the pipeline has filled and until all k have left.
  assign res   = (runCnt_q >= PIPE_LAT_C) && (runCnt_q < kExt + PIPE_LAT_C);
  assign srcOk = (state_q == S_RUN) ? a_valid_i : (state_q == S_DRAIN);
  assign step  = ((state_q == S_RUN) || (state_q == S_DRAIN)) && srcOk && (!res || out_ready_i);

  always_comb begin
    arr_ctrl_o  = MAC_CTRL_IDLE;
    arr_sel_o   = 2'd0;
    w_ready_o   = 1'b0;
    a_ready_o   = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      S_CLR: arr_ctrl_o = MAC_CTRL_CLR;
      S_LOAD: begin
        w_ready_o  = 1'b1;
        arr_sel_o  = 2'd1;
        arr_ctrl_o = w_valid_i ? MAC_CTRL_LOAD_WEIGHT : MAC_CTRL_IDLE;
      end
      S_RUN: begin
        arr_sel_o   = 2'd2;
        a_ready_o   = !res || out_ready_i;
        arr_ctrl_o  = step ? MAC_CTRL_RUN : MAC_CTRL_IDLE;
        out_valid_o = res && srcOk;
      end
      S_DRAIN: begin
        arr_ctrl_o  = step ? MAC_CTRL_RUN : MAC_CTRL_IDLE;
        out_valid_o = res && srcOk;
      end
      default: ;
    endcase
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

  // A zero-length job skips the array entirely and goes straight to the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      wCnt_q   <= '0;
      runCnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            if (cfg_k_i == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              k_q      <= kClamped;
              wCnt_q   <= '0;
              runCnt_q <= '0;
              state_q  <= S_CLR;
            end
          end
        end
        S_CLR: state_q <= S_LOAD;
        S_LOAD: begin
          if (w_valid_i) begin
            if (wCnt_q == W_W'(ARRAY_DIM-1)) begin
              wCnt_q  <= '0;
              state_q <= S_RUN;
            end else begin
              wCnt_q <= wCnt_q + W_W'(1);
            end
          end
        end
        S_RUN: begin
          if (step) begin
            runCnt_q <= runCnt_q + RC_W'(1);
            if (runCnt_q == kExt - RC_W'(1)) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (step) begin
            if (runCnt_q == lastStep) begin
              runCnt_q <= '0;
              state_q  <= S_DONE;
              done_q   <= 1'b1;
            end else begin
              runCnt_q <= runCnt_q + RC_W'(1);
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: an event-count job model checked every cycle, plus literal
// per-scenario timing (done cycle, result cycles, delivered results).
module tb_systolic_seq_ctrl;
  import mac_pkg::*;

  localparam int N    = 4;
  localparam int KMAX = 256;
  localparam int PL   = 2*N-1;
  localparam int KW   = $clog2(KMAX+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [KW-1:0] cfg_k_i = '0;
  logic          w_valid_i = 1'b0;
  logic          a_valid_i = 1'b0;
  logic          out_ready_i = 1'b0;
  logic          busy_o, done_o, w_ready_o, a_ready_o, out_valid_o;
  mac_ctrl_t     arr_ctrl_o;
  logic [1:0]    arr_sel_o;

  systolic_seq_ctrl #(.ARRAY_DIM(N), .K_MAX(KMAX)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .cfg_k_i(cfg_k_i),
    .busy_o(busy_o), .done_o(done_o), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .arr_ctrl_o(arr_ctrl_o), .arr_sel_o(arr_sel_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = -1;

  // Job model: progress is tracked as counts of events (weights taken, array steps taken).
  bit mActive = 1'b0, mClr = 1'b0, mDonePh = 1'b0;
  int mK = 0, mW = 0, mSteps = 0;

  int dutDoneCnt, dutDoneCyc, mdlDoneCnt, mdlDoneCyc, dutDeliv, busyFirst, busyLast;
  logic [63:0] dutOvMask, mdlOvMask;
  bit wReadySeen, aReadySeen, ctrlSeen;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int eCtrl, eSel, r;
    bit eW, eA, eOv, eBusy, eDone, running, res, feed, go;
    eCtrl = int'(MAC_CTRL_IDLE); eSel = 0; r = 0;
    eW = 0; eA = 0; eOv = 0; eBusy = 0; eDone = 0;
    running = 0; res = 0; feed = 0; go = 0;
    if (rst_n) begin
      if (mDonePh) begin
        eDone = 1; eBusy = 1;
      end else if (mActive) begin
        eBusy = 1;
        if (mClr) begin
          eCtrl = int'(MAC_CTRL_CLR);
        end else if (mW < N) begin
          eW = 1; eSel = 1;
          eCtrl = w_valid_i ? int'(MAC_CTRL_LOAD_WEIGHT) : int'(MAC_CTRL_IDLE);
        end else begin
          running = mSteps < mK;
          r       = mSteps - PL;
          res     = (r >= 0) && (r < mK);
          feed    = running ? a_valid_i : 1'b1;
          go      = feed && (!res || out_ready_i);
          eCtrl   = go ? int'(MAC_CTRL_RUN) : int'(MAC_CTRL_IDLE);
          eSel    = running ? 2 : 0;
          eA      = running && (!res || out_ready_i);
          eOv     = res && feed;
        end
      end
    end

    checkOutput("arr_ctrl", 32'(arr_ctrl_o), 32'(eCtrl));
    checkOutput("arr_sel", 32'(arr_sel_o), 32'(eSel));
    checkOutput("w_ready", 32'(w_ready_o), 32'(eW));
    checkOutput("a_ready", 32'(a_ready_o), 32'(eA));
    checkOutput("out_valid", 32'(out_valid_o), 32'(eOv));
    checkOutput("busy", 32'(busy_o), 32'(eBusy));
    checkOutput("done", 32'(done_o), 32'(eDone));

    if (done_o === 1'b1) begin dutDoneCnt++; dutDoneCyc = cyc; end
    if (eDone) begin mdlDoneCnt++; mdlDoneCyc = cyc; end
    if (out_valid_o === 1'b1 && cyc >= 0 && cyc < 64) dutOvMask[cyc] = 1'b1;
    if (eOv && cyc >= 0 && cyc < 64) mdlOvMask[cyc] = 1'b1;
    if (out_valid_o === 1'b1 && out_ready_i) dutDeliv++;
    if (busy_o === 1'b1) begin
      if (busyFirst < 0) busyFirst = cyc;
      busyLast = cyc;
    end
    if (w_ready_o === 1'b1) wReadySeen = 1;
    if (a_ready_o === 1'b1) aReadySeen = 1;
    if (arr_ctrl_o !== MAC_CTRL_IDLE) ctrlSeen = 1;

    // Advance the model to what the coming clock edge should produce.
    if (!rst_n) begin
      mActive = 0; mClr = 0; mDonePh = 0; mW = 0; mSteps = 0;
    end else if (mDonePh) begin
      mDonePh = 0;
    end else if (!mActive) begin
      if (start_i) begin
        if (cfg_k_i == 0) begin
          mDonePh = 1;
        end else begin
          mActive = 1; mClr = 1; mW = 0; mSteps = 0;
          mK = (int'(cfg_k_i) > KMAX) ? KMAX : int'(cfg_k_i);
        end
      end
    end else if (mClr) begin
      mClr = 0;
    end else if (mW < N) begin
      if (w_valid_i) mW++;
    end else if (go) begin
      mSteps++;
      if (mSteps == mK + PL) begin
        mActive = 0; mDonePh = 1;
      end
    end
  end

  task automatic applyStimulus(input int testId, input int nCycles);
    for (int c = 0; c < nCycles; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        dutDoneCnt = 0; dutDoneCyc = -1; mdlDoneCnt = 0; mdlDoneCyc = -1; dutDeliv = 0;
        busyFirst = -1; busyLast = -1; dutOvMask = '0; mdlOvMask = '0;
        wReadySeen = 0; aReadySeen = 0; ctrlSeen = 0;
      end
      cyc         = c;
      start_i     = (c == 0);
      cfg_k_i     = KW'(3);
      w_valid_i   = 1'b1;
      a_valid_i   = 1'b1;
      out_ready_i = 1'b1;
      rst_n       = 1'b1;
      case (testId)
        2: w_valid_i = (c != 3);
        3: out_ready_i = !(c == 13 || c == 14);
        4: cfg_k_i = '0;
        5: begin
          rst_n   = !(c == 8 || c == 9);
          start_i = (c == 0 || c == 12);
        end
        6: begin
          start_i = (c == 0 || c == 4 || c == 10);
          cfg_k_i = (c == 0) ? KW'(3) : KW'(7);
        end
        7: cfg_k_i = KW'(300);
        8: cfg_k_i = KW'(1);
        default: ;
      endcase
    end
    @(negedge clk);
    #1;
  endtask

  task automatic checkJob(input string tag, input int expDone, input int expCnt,
                          input logic [63:0] expMask, input int expDeliv);
    checkOutput({tag, "_dut_done_cyc"}, 32'(dutDoneCyc), 32'(expDone));
    checkOutput({tag, "_mdl_done_cyc"}, 32'(mdlDoneCyc), 32'(expDone));
    checkOutput({tag, "_done_cnt"}, 32'(dutDoneCnt), 32'(expCnt));
    checkOutput({tag, "_ov_lo"}, dutOvMask[31:0], expMask[31:0]);
    checkOutput({tag, "_ov_hi"}, dutOvMask[63:32], expMask[63:32]);
    checkOutput({tag, "_mdl_ov_lo"}, mdlOvMask[31:0], expMask[31:0]);
    checkOutput({tag, "_delivered"}, 32'(dutDeliv), 32'(expDeliv));
    checkOutput({tag, "_busy_first"}, 32'(busyFirst), 32'(1));
    checkOutput({tag, "_busy_last"}, 32'(busyLast), 32'(expDone));
  endtask

  initial begin
    $display("[TB] reset phase");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    applyStimulus(1, 20);
    checkJob("t1", 16, 1, 64'h0000_E000, 3);
    applyStimulus(2, 21);
    checkJob("t2", 17, 1, 64'h0001_C000, 3);
    applyStimulus(3, 22);
    checkJob("t3", 18, 1, 64'h0003_E000, 3);
    applyStimulus(4, 6);
    checkJob("t4", 1, 1, 64'h0, 0);
    checkOutput("t4_w_ready_seen", 32'(wReadySeen), 32'(0));
    checkOutput("t4_a_ready_seen", 32'(aReadySeen), 32'(0));
    checkOutput("t4_ctrl_seen", 32'(ctrlSeen), 32'(0));
    applyStimulus(5, 32);
    checkJob("t5", 28, 1, 64'h0E00_0000, 3);
    applyStimulus(6, 22);
    checkJob("t6", 16, 1, 64'h0000_E000, 3);
    applyStimulus(7, 274);
    checkJob("t7", 269, 1, 64'hFFFF_FFFF_FFFF_E000, 256);
    applyStimulus(8, 18);
    checkJob("t8", 14, 1, 64'h0000_2000, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
